nv12_frame_arbiter: RTL and testbench

Frame-level scheduler that shares one NV12→BGR conversion kernel (height/width-configured, ap_start/ap_done controlled) between two NV12 input channels. Each channel supplies per-frame row/column descriptors through FIFOs. The block arbitrates round-robin between the channels, validates the frame dimensions, and drives the kernel's start handshake and dimension inputs. It steers the shared Y/UV data mux, counts written BGR pixels and reports per-frame completion and errors. It sits between the two descriptor producers and the single conversion kernel instance in the pre-processing pipeline.

---
 rtl/nv12_frame_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_nv12_frame_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv12_frame_arbiter.sv
// nv12_frame_arbiter
// Frame-level scheduler that shares one NV12->BGR conversion kernel between
// two descriptor channels. It grants round-robin, validates the frame
// geometry, runs the kernel start/done handshake, counts accepted BGR
// writes and reports completion, rejects and pixel-count mismatches.

module nv12_frame_arbiter #(
  parameter int MAX_ROWS = 2160,
  parameter int MAX_COLS = 3840
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        en,
  input  logic [31:0] ch0_rows_dout,
  input  logic        ch0_rows_empty_n,
  output logic        ch0_rows_read,
  input  logic [31:0] ch0_cols_dout,
  input  logic        ch0_cols_empty_n,
  output logic        ch0_cols_read,
  input  logic [31:0] ch1_rows_dout,
  input  logic        ch1_rows_empty_n,
  output logic        ch1_rows_read,
  input  logic [31:0] ch1_cols_dout,
  input  logic        ch1_cols_empty_n,
  output logic        ch1_cols_read,
  output logic        k_start,
  input  logic        k_ready,
  input  logic        k_done,
  output logic [15:0] k_height,
  output logic [15:0] k_width,
  output logic        k_sel,
  input  logic        k_write,
  input  logic        out_full_n,
  output logic        busy,
  output logic        frame_done,
  output logic        done_ch,
  output logic        mismatch,
  output logic        reject,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_MAX_ROWS = 16'(MAX_ROWS);
  localparam logic [15:0] LP_MAX_COLS = 16'(MAX_COLS);

  state_t      r_state;
  logic        r_lastGrant;
  logic        r_valid;
  logic [31:0] r_pixCnt;
  logic        r_kStart;
  logic [15:0] r_kHeight;
  logic [15:0] r_kWidth;
  logic        r_kSel;
  logic        r_busy;
  logic        r_frameDone;
  logic        r_doneCh;
  logic        r_mismatch;
  logic        r_reject;
  logic [7:0]  r_errCnt;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_anyGrant;
  logic [15:0] w_rows;
  logic [15:0] w_cols;
  logic        w_descOk;
  logic        w_pixInc;
  logic [31:0] w_pixNext;
  logic [31:0] w_area;
  logic        w_mismatch;
  logic        w_finish;
  logic [7:0]  w_errSat;
  logic        w_unused;

  // Upper descriptor bits carry no meaning for this block.
  assign w_unused = ^{ch0_rows_dout[31:16], ch0_cols_dout[31:16],
                      ch1_rows_dout[31:16], ch1_cols_dout[31:16]};

  // A channel may be granted only when both of its descriptor FIFOs hold data;
  // on a tie the channel that did not win last time goes first. Reset blocks
  // pops so pending descriptors survive a mid-frame reset.
  assign w_elig0    = en & ch0_rows_empty_n & ch0_cols_empty_n;
  assign w_elig1    = en & ch1_rows_empty_n & ch1_cols_empty_n;
  assign w_grant0   = (r_state == S_IDLE) & ~ap_rst & w_elig0 & (~w_elig1 | r_lastGrant);
  assign w_grant1   = (r_state == S_IDLE) & ~ap_rst & w_elig1 & (~w_elig0 | ~r_lastGrant);
  assign w_anyGrant = w_grant0 | w_grant1;

  assign ch0_rows_read = w_grant0;
  assign ch0_cols_read = w_grant0;
  assign ch1_rows_read = w_grant1;
  assign ch1_cols_read = w_grant1;

  // Geometry of the descriptor being popped; NV12 4:2:0 needs even sizes.
  assign w_rows   = w_grant1 ? ch1_rows_dout[15:0] : ch0_rows_dout[15:0];
  assign w_cols   = w_grant1 ? ch1_cols_dout[15:0] : ch0_cols_dout[15:0];
  assign w_descOk = (w_rows != 16'd0) && (w_cols != 16'd0) &&
                    (w_rows <= LP_MAX_ROWS) && (w_cols <= LP_MAX_COLS) &&
                    !w_rows[0] && !w_cols[0];

  // Pixel count includes a write landing on the same edge as k_done, and
  // sticks at all-ones instead of wrapping.
  assign w_pixInc   = ((r_state == S_START) || (r_state == S_RUN)) & k_write & out_full_n;
  assign w_pixNext  = (w_pixInc && (r_pixCnt != 32'hFFFF_FFFF)) ? r_pixCnt + 32'd1 : r_pixCnt;
  assign w_area     = 32'(r_kHeight) * 32'(r_kWidth);
  assign w_mismatch = (w_pixNext != w_area);
  assign w_finish   = k_done & (((r_state == S_START) & k_ready) | (r_state == S_RUN));
  assign w_errSat   = (r_errCnt != 8'hFF) ? r_errCnt + 8'd1 : r_errCnt;

  // Frame scheduler: grant, validate, kernel handshake and completion report.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b1;
      r_valid     <= 1'b0;
      r_pixCnt    <= 32'd0;
      r_kStart    <= 1'b0;
      r_kHeight   <= 16'd0;
      r_kWidth    <= 16'd0;
      r_kSel      <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_doneCh    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_reject    <= 1'b0;
      r_errCnt    <= 8'd0;
    end else begin
      r_frameDone <= 1'b0;
      r_mismatch  <= 1'b0;
      r_reject    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_anyGrant) begin
            r_kHeight   <= w_rows;
            r_kWidth    <= w_cols;
            r_kSel      <= w_grant1;
            r_lastGrant <= w_grant1;
            r_valid     <= w_descOk;
            r_busy      <= 1'b1;
            r_state     <= S_CHECK;
            if (!w_descOk) begin
              r_reject <= 1'b1;
              r_doneCh <= w_grant1;
              r_errCnt <= w_errSat;
            end
          end
        end
        S_CHECK: begin
          if (r_valid) begin
            r_pixCnt <= 32'd0;
            r_kStart <= 1'b1;
            r_state  <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_pixCnt <= w_pixNext;
          if (k_ready) begin
            r_kStart <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_pixCnt <= w_pixNext;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_finish) begin
        r_state     <= S_DONE;
        r_frameDone <= 1'b1;
        r_doneCh    <= r_kSel;
        r_mismatch  <= w_mismatch;
        if (w_mismatch) begin
          r_errCnt <= w_errSat;
        end
      end
    end
  end

  assign k_start    = r_kStart;
  assign k_height   = r_kHeight;
  assign k_width    = r_kWidth;
  assign k_sel      = r_kSel;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;
  assign done_ch    = r_doneCh;
  assign mismatch   = r_mismatch;
  assign reject     = r_reject;
  assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_nv12_frame_arbiter.sv
// Testbench for nv12_frame_arbiter: descriptor FIFOs and a directed kernel
// responder drive the DUT, while a frame-level reference model predicts every
// output each cycle; directed literal checks pin the model's key results.

module tb_nv12_frame_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] ch0_rows_dout, ch0_cols_dout, ch1_rows_dout, ch1_cols_dout;
  logic        ch0_rows_empty_n, ch0_cols_empty_n, ch1_rows_empty_n, ch1_cols_empty_n;
  logic        ch0_rows_read, ch0_cols_read, ch1_rows_read, ch1_cols_read;
  logic        k_start;
  logic        k_ready = 1'b0;
  logic        k_done = 1'b0;
  logic        k_write = 1'b0;
  logic        out_full_n = 1'b1;
  logic [15:0] k_height, k_width;
  logic        k_sel, busy, frame_done, done_ch, mismatch, reject;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  nv12_frame_arbiter dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .en(en),
    .ch0_rows_dout(ch0_rows_dout), .ch0_rows_empty_n(ch0_rows_empty_n), .ch0_rows_read(ch0_rows_read),
    .ch0_cols_dout(ch0_cols_dout), .ch0_cols_empty_n(ch0_cols_empty_n), .ch0_cols_read(ch0_cols_read),
    .ch1_rows_dout(ch1_rows_dout), .ch1_rows_empty_n(ch1_rows_empty_n), .ch1_rows_read(ch1_rows_read),
    .ch1_cols_dout(ch1_cols_dout), .ch1_cols_empty_n(ch1_cols_empty_n), .ch1_cols_read(ch1_cols_read),
    .k_start(k_start), .k_ready(k_ready), .k_done(k_done),
    .k_height(k_height), .k_width(k_width), .k_sel(k_sel),
    .k_write(k_write), .out_full_n(out_full_n),
    .busy(busy), .frame_done(frame_done), .done_ch(done_ch),
    .mismatch(mismatch), .reject(reject), .err_cnt(err_cnt)
  );

  // Four descriptor FIFOs as flat arrays with free-running indices.
  logic [31:0] f0r [0:1023];
  logic [31:0] f0c [0:1023];
  logic [31:0] f1r [0:1023];
  logic [31:0] f1c [0:1023];
  int w0r = 0, r0r = 0, w0c = 0, r0c = 0, w1r = 0, r1r = 0, w1c = 0, r1c = 0;

  assign ch0_rows_dout    = f0r[r0r[9:0]];
  assign ch0_cols_dout    = f0c[r0c[9:0]];
  assign ch1_rows_dout    = f1r[r1r[9:0]];
  assign ch1_cols_dout    = f1c[r1c[9:0]];
  assign ch0_rows_empty_n = (w0r != r0r);
  assign ch0_cols_empty_n = (w0c != r0c);
  assign ch1_rows_empty_n = (w1r != r1r);
  assign ch1_cols_empty_n = (w1c != r1c);

  // FIFO pops follow the DUT read strobes.
  always @(posedge ap_clk) begin
    if (ch0_rows_read) r0r <= r0r + 1;
    if (ch0_cols_read) r0c <= r0c + 1;
    if (ch1_rows_read) r1r <= r1r + 1;
    if (ch1_cols_read) r1c <= r1c + 1;
  end

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_JUDGE, M_LAUNCH, M_KERNEL, M_REPORT} mphase_t;
  mphase_t mPhase = M_IDLE;
  bit      mLive = 1'b0;
  int      mLast = 1;
  bit      mOk = 1'b0;
  longint  mPix = 0;
  int      eKH = 0, eKW = 0, eKSel = 0, eDoneCh = 0, eErrCnt = 0;
  bit      eKStart = 0, eBusy = 0, eFrameDone = 0, eMismatch = 0, eReject = 0;

  function automatic int pickChannel();
    bit e0, e1;
    e0 = en && ch0_rows_empty_n && ch0_cols_empty_n;
    e1 = en && ch1_rows_empty_n && ch1_cols_empty_n;
    if (e0 && e1) return (mLast == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void modelFinish();
    longint area;
    area = longint'(eKH) * longint'(eKW);
    mPhase     = M_REPORT;
    eFrameDone = 1'b1;
    eDoneCh    = eKSel;
    eMismatch  = (mPix != area);
    if (eMismatch && eErrCnt < 255) eErrCnt++;
  endfunction

  // Model advances one clock using the inputs present at the edge.
  always @(posedge ap_clk) begin
    int g, rows, cols;
    if (ap_rst) begin
      mLive = 1'b1; mPhase = M_IDLE; mLast = 1; mPix = 0; mOk = 1'b0;
      eKH = 0; eKW = 0; eKSel = 0; eDoneCh = 0; eErrCnt = 0;
      eKStart = 0; eBusy = 0; eFrameDone = 0; eMismatch = 0; eReject = 0;
    end else begin
      eFrameDone = 0; eMismatch = 0; eReject = 0;
      case (mPhase)
        M_IDLE: begin
          g = pickChannel();
          if (g >= 0) begin
            rows = (g == 1) ? int'(ch1_rows_dout[15:0]) : int'(ch0_rows_dout[15:0]);
            cols = (g == 1) ? int'(ch1_cols_dout[15:0]) : int'(ch0_cols_dout[15:0]);
            eKH = rows; eKW = cols; eKSel = g; mLast = g;
            mOk = (rows != 0) && (cols != 0) && (rows <= 2160) && (cols <= 3840) &&
                  (rows % 2 == 0) && (cols % 2 == 0);
            if (!mOk) begin
              eReject = 1; eDoneCh = g;
              if (eErrCnt < 255) eErrCnt++;
            end
            mPhase = M_JUDGE;
          end
        end
        M_JUDGE: begin
          if (mOk) begin mPix = 0; eKStart = 1; mPhase = M_LAUNCH; end
          else mPhase = M_IDLE;
        end
        M_LAUNCH: begin
          if (k_write && out_full_n) mPix++;
          if (k_ready) begin
            eKStart = 0;
            if (k_done) modelFinish();
            else mPhase = M_KERNEL;
          end
        end
        M_KERNEL: begin
          if (k_write && out_full_n) mPix++;
          if (k_done) modelFinish();
        end
        default: mPhase = M_IDLE;
      endcase
      eBusy = (mPhase != M_IDLE);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state used by the directed literal checks.
  int cyc = 0, firstPopCyc = -1, firstStartCyc = -1, firstRejectCyc = -1;
  int kStartCycles = 0, rejectCnt = 0, doneCnt = 0, rd0Cnt = 0, rd1Cnt = 0;
  int lastMismatch = -1, lastDoneCh = -1;
  int grantQ[$];

  // Per-cycle compare against the model, then bookkeeping for directed checks.
  always @(negedge ap_clk) begin
    int p;
    if (mLive) begin
      p = pickChannel();
      checkOutput("ch0_rows_read", 32'(ch0_rows_read), 32'(!ap_rst && mPhase == M_IDLE && p == 0));
      checkOutput("ch0_cols_read", 32'(ch0_cols_read), 32'(!ap_rst && mPhase == M_IDLE && p == 0));
      checkOutput("ch1_rows_read", 32'(ch1_rows_read), 32'(!ap_rst && mPhase == M_IDLE && p == 1));
      checkOutput("ch1_cols_read", 32'(ch1_cols_read), 32'(!ap_rst && mPhase == M_IDLE && p == 1));
      checkOutput("k_start", 32'(k_start), 32'(eKStart));
      checkOutput("k_height", 32'(k_height), 32'(eKH));
      checkOutput("k_width", 32'(k_width), 32'(eKW));
      checkOutput("k_sel", 32'(k_sel), 32'(eKSel));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("frame_done", 32'(frame_done), 32'(eFrameDone));
      checkOutput("done_ch", 32'(done_ch), 32'(eDoneCh));
      checkOutput("mismatch", 32'(mismatch), 32'(eMismatch));
      checkOutput("reject", 32'(reject), 32'(eReject));
      checkOutput("err_cnt", 32'(err_cnt), 32'(eErrCnt));
    end
    cyc++;
    if (ch0_rows_read) begin grantQ.push_back(0); rd0Cnt++; if (firstPopCyc < 0) firstPopCyc = cyc; end
    if (ch1_rows_read) begin grantQ.push_back(1); rd1Cnt++; if (firstPopCyc < 0) firstPopCyc = cyc; end
    if (k_start === 1'b1) begin kStartCycles++; if (firstStartCyc < 0) firstStartCyc = cyc; end
    if (reject === 1'b1) begin rejectCnt++; if (firstRejectCyc < 0) firstRejectCyc = cyc; end
    if (frame_done === 1'b1) begin doneCnt++; lastMismatch = int'(mismatch); lastDoneCh = int'(done_ch); end
  end

  task automatic clearMon();
    firstPopCyc = -1; firstStartCyc = -1; firstRejectCyc = -1;
    kStartCycles = 0; rejectCnt = 0; doneCnt = 0; rd0Cnt = 0; rd1Cnt = 0;
    lastMismatch = -1; lastDoneCh = -1;
    grantQ.delete();
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic doReset();
    ap_rst = 1'b1;
    step();
    step();
    ap_rst = 1'b0;
  endtask

  task automatic pushRows(input int ch, input int v);
    if (ch == 0) begin f0r[w0r[9:0]] = 32'(v); w0r++; end
    else begin f1r[w1r[9:0]] = 32'(v); w1r++; end
  endtask

  task automatic pushCols(input int ch, input int v);
    if (ch == 0) begin f0c[w0c[9:0]] = 32'(v); w0c++; end
    else begin f1c[w1c[9:0]] = 32'(v); w1c++; end
  endtask

  task automatic pushDesc(input int ch, input int rows, input int cols);
    pushRows(ch, rows);
    pushCols(ch, cols);
  endtask

  task automatic waitStart();
    int waited = 0;
    while (k_start !== 1'b1 && waited < 60) begin step(); waited++; end
    checkOutput("kStartSeen", 32'(k_start), 32'd1);
  endtask

  // Kernel responder for one frame: ready after a delay, a burst of writes
  // (optionally with the output FIFO alternating full), then done.
  task automatic applyStimulus(input int readyDelay, input int writes, input bit toggleFull);
    waitStart();
    if (k_start === 1'b1) begin
      for (int i = 0; i < readyDelay; i++) step();
      k_ready = 1'b1;
      step();
      k_ready = 1'b0;
      for (int i = 0; i < writes; i++) begin
        k_write = 1'b1;
        out_full_n = toggleFull ? ((i % 2) == 0) : 1'b1;
        step();
      end
      k_write = 1'b0;
      out_full_n = 1'b1;
      k_done = 1'b1;
      step();
      k_done = 1'b0;
      step();
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pending, waited;
    int expOrder[4];
    expOrder[0] = 0; expOrder[1] = 1; expOrder[2] = 0; expOrder[3] = 1;
    for (int i = 0; i < 1024; i++) begin
      f0r[i] = 32'd0; f0c[i] = 32'd0; f1r[i] = 32'd0; f1c[i] = 32'd0;
    end

    $display("[TB] reset values");
    doReset();
    checkOutput("rstKStart", 32'(k_start), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("rstKHeight", 32'(k_height), 32'd0);

    $display("[TB] single 4x6 frame on ch0");
    clearMon();
    pushDesc(0, 4, 6);
    applyStimulus(0, 24, 1'b0);
    checkOutput("t1StartLatency", 32'(firstStartCyc - firstPopCyc), 32'd2);
    checkOutput("t1Pops", 32'(rd0Cnt), 32'd1);
    checkOutput("t1Height", 32'(k_height), 32'd4);
    checkOutput("t1Width", 32'(k_width), 32'd6);
    checkOutput("t1DoneCh", 32'(lastDoneCh), 32'd0);
    checkOutput("t1Mismatch", 32'(lastMismatch), 32'd0);

    $display("[TB] round robin, both channels loaded");
    doReset();
    clearMon();
    pushDesc(0, 2, 2); pushDesc(0, 2, 2);
    pushDesc(1, 2, 2); pushDesc(1, 2, 2);
    for (int f = 0; f < 4; f++) applyStimulus(0, 4, 1'b0);
    checkOutput("t2Grants", 32'(grantQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < grantQ.size(); i++) checkOutput("t2Order", 32'(grantQ[i]), 32'(expOrder[i]));
    checkOutput("t2Frames", 32'(doneCnt), 32'd4);

    $display("[TB] ch1 rejects and stray k_done");
    doReset();
    clearMon();
    pushDesc(1, 0, 4);
    pushDesc(1, 2162, 4);
    pushDesc(1, 2, 7);
    step();
    k_done = 1'b1;
    step();
    k_done = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checkOutput("t3Rejects", 32'(rejectCnt), 32'd3);
    checkOutput("t3ErrCnt", 32'(err_cnt), 32'd3);
    checkOutput("t3NoStart", 32'(kStartCycles), 32'd0);
    checkOutput("t3RejectLatency", 32'(firstRejectCyc - firstPopCyc), 32'd1);
    checkOutput("t3DoneCh", 32'(done_ch), 32'd1);
    clearMon();
    pushRows(0, 2);
    for (int i = 0; i < 4; i++) step();
    checkOutput("t3HalfDescNoPop", 32'(rd0Cnt), 32'd0);
    pushCols(0, 3);
    for (int i = 0; i < 4; i++) step();
    checkOutput("t3OddColsErr", 32'(err_cnt), 32'd4);

    $display("[TB] short frame with output back-pressure");
    clearMon();
    pushDesc(0, 2, 2);
    applyStimulus(0, 5, 1'b1);
    checkOutput("t4Mismatch", 32'(lastMismatch), 32'd1);
    checkOutput("t4ErrCnt", 32'(err_cnt), 32'd5);

    $display("[TB] delayed k_ready");
    clearMon();
    pushDesc(1, 2, 2);
    applyStimulus(5, 4, 1'b0);
    checkOutput("t5StartHeld", 32'(kStartCycles), 32'd6);
    checkOutput("t5Mismatch", 32'(lastMismatch), 32'd0);

    $display("[TB] grants disabled");
    en = 1'b0;
    pushDesc(0, 2, 2);
    pushDesc(1, 2, 2);
    clearMon();
    for (int i = 0; i < 5; i++) step();
    checkOutput("t5EnOffReads", 32'(rd0Cnt + rd1Cnt), 32'd0);
    checkOutput("t5EnOffBusy", 32'(busy), 32'd0);
    en = 1'b1;
    applyStimulus(0, 4, 1'b0);
    applyStimulus(0, 4, 1'b0);

    $display("[TB] error counter saturation");
    doReset();
    clearMon();
    for (int i = 0; i < 300; i++) pushDesc(0, 0, 2);
    waited = 0;
    while (w0r != r0r && waited < 800) begin step(); waited++; end
    pending = w0r - r0r;
    checkOutput("t6Drained", 32'(pending), 32'd0);
    step();
    step();
    checkOutput("t6ErrSat", 32'(err_cnt), 32'd255);
    checkOutput("t6Rejects", 32'(rejectCnt), 32'd300);

    $display("[TB] reset during kernel run");
    doReset();
    pushDesc(0, 4, 4);
    waitStart();
    k_ready = 1'b1;
    step();
    k_ready = 1'b0;
    k_write = 1'b1;
    step();
    step();
    pushDesc(1, 2, 2);
    k_write = 1'b0;
    ap_rst = 1'b1;
    step();
    checkOutput("t7KStart", 32'(k_start), 32'd0);
    checkOutput("t7Busy", 32'(busy), 32'd0);
    checkOutput("t7Height", 32'(k_height), 32'd0);
    checkOutput("t7Width", 32'(k_width), 32'd0);
    pending = w1r - r1r;
    checkOutput("t7Ch1Kept", 32'(pending), 32'd1);
    ap_rst = 1'b0;
    applyStimulus(0, 4, 1'b0);
    checkOutput("t7AfterDoneCh", 32'(done_ch), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
